// File: rtl/class_vec_seq_ctrl_if.sv
// Beat stream from the class vector sequencer.
// Master drives the frame beat, slave returns ready.
interface class_vec_seq_ctrl_if #(
  parameter int FRAME_W = 64,
  parameter int PC_W    = $clog2(FRAME_W + 1)
) ();
  logic [FRAME_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_class;
  logic [1:0]         out_frame;
  logic               out_last_frame;
  logic               out_last;
  logic [PC_W-1:0]    out_popcnt;

  modport master (
    output out_data, out_valid, out_class, out_frame,
    output out_last_frame, out_last, out_popcnt,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_class, out_frame,
    input  out_last_frame, out_last, out_popcnt,
    output out_ready
  );
endinterface

// File: rtl/class_vec_seq_ctrl.sv
// Sequencer streaming class hypervector frames from a generator.
// Optional popcount of each beat: define CLASS_SEQ_POPCNT_EN.
module class_vec_seq_ctrl #(
  parameter int NUM_CLASSES = 8,
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_W     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               sweep_i,
  input  logic [2:0]         start_class_i,
  input  logic               abort_i,
  output logic [2:0]         gen_frame_id_o,
  output logic [1:0]         gen_frame_index_o,
  input  logic [FRAME_W-1:0] gen_vec_i,
  class_vec_seq_ctrl_if.master bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int PC_W = $clog2(FRAME_W + 1);
  localparam logic [3:0] NC = 4'(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_e;

  state_e             state_q;
  logic [2:0]         cls_q, cls_d;
  logic [1:0]         frm_q, frm_d;
  logic               sweep_q;
  logic [FRAME_W-1:0] data_q;
  logic               valid_q;
  logic [2:0]         ocls_q;
  logic [1:0]         ofrm_q;
  logic               lastf_q, lastf_d;
  logic               last_q, last_d;
  logic               busy_q, done_q, err_q;
  logic               start_ok;
  logic               frm_end, cls_end;

  // Next address and last-beat flags for the frame being fetched
  always_comb begin
    frm_end  = (frm_q == 2'(NUM_FRAMES - 1));
    cls_end  = (cls_q == 3'(NUM_CLASSES - 1));
    lastf_d  = frm_end;
    last_d   = frm_end && (!sweep_q || cls_end);
    start_ok = sweep_i || ({1'b0, start_class_i} < NC);
    frm_d    = frm_q + 2'd1;
    cls_d    = cls_q;
    if (frm_end) begin
      frm_d = '0;
      cls_d = cls_q + 3'd1;
    end
  end

`ifdef CLASS_SEQ_POPCNT_EN
  logic [PC_W-1:0] pc_d, pc_q;

  // Ones count of the frame currently presented by the generator
  always_comb begin
    pc_d = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      pc_d = pc_d + PC_W'(gen_vec_i[i]);
    end
  end

  assign bus.out_popcnt = pc_q;
`else
  assign bus.out_popcnt = '0;
`endif

  // Control FSM with all beat outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q   <= '0;
      frm_q   <= '0;
      sweep_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ocls_q  <= '0;
      ofrm_q  <= '0;
      lastf_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CLASS_SEQ_POPCNT_EN
      pc_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (start_ok) begin
              cls_q   <= sweep_i ? 3'd0 : start_class_i;
              frm_q   <= '0;
              sweep_q <= sweep_i;
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (abort_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            data_q  <= gen_vec_i;
            ocls_q  <= cls_q;
            ofrm_q  <= frm_q;
            lastf_q <= lastf_d;
            last_q  <= last_d;
            valid_q <= 1'b1;
`ifdef CLASS_SEQ_POPCNT_EN
            pc_q    <= pc_d;
`endif
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (abort_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cls_q   <= cls_d;
              frm_q   <= frm_d;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gen_frame_id_o     = cls_q;
  assign gen_frame_index_o  = frm_q;
  assign bus.out_data       = data_q;
  assign bus.out_valid      = valid_q;
  assign bus.out_class      = ocls_q;
  assign bus.out_frame      = ofrm_q;
  assign bus.out_last_frame = lastf_q;
  assign bus.out_last       = last_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_class_vec_seq_ctrl.sv
// Directed + randomized bench for class_vec_seq_ctrl.
// Reference: expected beat list built from class/frame rules.
module tb_class_vec_seq_ctrl;

  localparam int NC = 8;
  localparam int NF = 3;
  localparam int W  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, sweep, abort;
  logic [2:0]   start_class, gid;
  logic [1:0]   gidx;
  logic [W-1:0] gvec;
  logic         busy, done, err;

  logic         start6, abort6;
  logic [2:0]   sc6, gid6;
  logic [1:0]   gidx6;
  logic         busy6, done6, err6;

  class_vec_seq_ctrl_if #(.FRAME_W(W)) bus ();
  class_vec_seq_ctrl_if #(.FRAME_W(W)) bus6 ();

  assign bus6.out_ready = 1'b1;

  class_vec_seq_ctrl #(
    .NUM_CLASSES(NC), .NUM_FRAMES(NF), .FRAME_W(W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .start_i(start), .sweep_i(sweep),
    .start_class_i(start_class), .abort_i(abort),
    .gen_frame_id_o(gid), .gen_frame_index_o(gidx),
    .gen_vec_i(gvec), .bus(bus.master),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  class_vec_seq_ctrl #(
    .NUM_CLASSES(6), .NUM_FRAMES(NF), .FRAME_W(W)
  ) u_dut6 (
    .clk(clk), .rst(rst),
    .start_i(start6), .sweep_i(1'b0),
    .start_class_i(sc6), .abort_i(abort6),
    .gen_frame_id_o(gid6), .gen_frame_index_o(gidx6),
    .gen_vec_i('0), .bus(bus6.master),
    .busy_o(busy6), .done_o(done6), .err_o(err6)
  );

  logic [W-1:0] vec_tab [NC][4];

  always_comb gvec = vec_tab[gid][gidx];

  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_pc(logic [63:0] v);
`ifdef CLASS_SEQ_POPCNT_EN
    return $countones(v);
`else
    return 0;
`endif
  endfunction

  typedef struct {
    int         c;
    int         f;
    logic [63:0] d;
    bit         lf;
    bit         l;
  } beat_t;

  beat_t q[$];

  task automatic build(input bit sw, input int sc);
    int lo, hi;
    beat_t b;
    q.delete();
    lo = sw ? 0 : sc;
    hi = sw ? NC - 1 : sc;
    for (int c = lo; c <= hi; c++) begin
      for (int f = 0; f < NF; f++) begin
        b.c  = c;
        b.f  = f;
        b.d  = vec_tab[c][f];
        b.lf = (f == NF - 1);
        b.l  = (f == NF - 1) && (c == hi);
        q.push_back(b);
      end
    end
  endtask

  // mode 0: ready always 1; 1: random; 2: low for first 5 valid cycles
  task automatic run_xfer(input bit sw, input bit [2:0] sc,
                          input int mode, input bit poke);
    int cyc, nval, first, donec, low, nb;
    bit got_done, sawerr, r;
    build(sw, sc);
    nb = q.size();
    @(negedge clk);
    start = 1'b1;
    sweep = sw;
    start_class = sc;
    bus.out_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0; nval = 0; first = -1; donec = -1; low = 0;
    got_done = 0; sawerr = 0;
    while (!got_done && cyc < 400) begin
      if (err) sawerr = 1;
      start = 1'b0;
      if (done) begin
        got_done = 1;
        donec = cyc;
        chk("done_queue_empty", q.size(), 0);
        chk("done_busy", busy, 1);
      end else begin
        if (bus.out_valid) begin
          if (first < 0) first = cyc;
          nval++;
          if (q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            chk("beat_class", bus.out_class, q[0].c);
            chk("beat_frame", bus.out_frame, q[0].f);
            chk("beat_data", bus.out_data, q[0].d);
            chk("beat_lastf", bus.out_last_frame, q[0].lf);
            chk("beat_last", bus.out_last, q[0].l);
            chk("beat_popcnt", bus.out_popcnt, exp_pc(q[0].d));
          end
          case (mode)
            0: r = 1'b1;
            1: r = 1'($urandom_range(0, 1));
            default: r = (low >= 5);
          endcase
          if (!r) low++;
          bus.out_ready = r;
          if (r && q.size() > 0) void'(q.pop_front());
        end else if (mode == 1) begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        if (poke && busy) begin
          start = 1'($urandom_range(0, 1));
          sweep = 1'($urandom_range(0, 1));
          start_class = 3'($urandom_range(0, 7));
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("beats_left", q.size(), 0);
    chk("no_err_pulse", sawerr, 0);
    chk("valid_cycles_min", nval >= nb, 1);
    if (mode == 0) begin
      chk("first_valid_latency", first, 1);
      chk("done_cycle", donec, 2 * nb);
      chk("valid_cycles", nval, nb);
    end
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; sweep = 1'b0;
    start_class = '0; abort = 1'b0;
    start6 = 1'b0; abort6 = 1'b0; sc6 = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < 4; f++)
        vec_tab[c][f] = {$urandom, $urandom};
    vec_tab[4][0] = '1;
    vec_tab[4][1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_class", bus.out_class, 0);
    chk("rst_frame", bus.out_frame, 0);
    chk("rst_lastf", bus.out_last_frame, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_popcnt", bus.out_popcnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_gid", gid, 0);
    chk("rst_gidx", gidx, 0);

    // full sweep, ready always high
    run_xfer(1'b1, 3'd0, 0, 1'b0);
    // single class 4, ready low for five valid cycles
    run_xfer(1'b0, 3'd4, 2, 1'b0);
    // highest class in single mode
    run_xfer(1'b0, 3'd7, 0, 1'b0);
    // random ready with ignored starts while busy
    run_xfer(1'b1, 3'd0, 1, 1'b1);
    run_xfer(1'b0, 3'd1, 1, 1'b1);

    // out-of-range class on a 6-class instance
    @(negedge clk);
    start6 = 1'b1; sc6 = 3'd7;
    @(negedge clk);
    start6 = 1'b0;
    chk("err6_pulse_c7", err6, 1);
    chk("err6_busy_c7", busy6, 0);
    @(negedge clk);
    chk("err6_one_cycle", err6, 0);
    start6 = 1'b1; sc6 = 3'd6;
    @(negedge clk);
    start6 = 1'b0;
    chk("err6_pulse_c6", err6, 1);
    start6 = 1'b1; sc6 = 3'd5;
    @(negedge clk);
    start6 = 1'b0;
    chk("err6_ok_c5", err6, 0);
    chk("busy6_c5", busy6, 1);
    abort6 = 1'b1;
    @(negedge clk);
    abort6 = 1'b0;
    chk("abort6_idle", busy6, 0);

    // abort while holding class 2 frame 1
    @(negedge clk);
    start = 1'b1; sweep = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.out_valid && bus.out_class == 3'd2 &&
          bus.out_frame == 2'd1) begin
        found = 1;
        abort = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("abort_point_found", found, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_gid_hold", gid, 2);
    chk("abort_gidx_hold", gidx, 1);
    @(negedge clk);
    chk("abort_no_late_done", done, 0);
    run_xfer(1'b0, 3'd2, 1, 1'b0);

    // reset mid-sweep overrides a simultaneous start
    @(negedge clk);
    start = 1'b1; sweep = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_class", bus.out_class, 0);
    chk("mid_rst_frame", bus.out_frame, 0);
    chk("mid_rst_lastf", bus.out_last_frame, 0);
    chk("mid_rst_last", bus.out_last, 0);
    chk("mid_rst_popcnt", bus.out_popcnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_gid", gid, 0);
    chk("mid_rst_gidx", gidx, 0);
    @(negedge clk);
    chk("mid_rst_stays_idle", busy, 0);
    run_xfer(1'b1, 3'd0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
